mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
// Multi-cycle successor to the single-cycle RV32I control unit. Sequences each instruction through IF/ID/EX/MEM/WB.
// Drives the datapath strobes and a ready-handshaked, variable-latency unified memory.
// Adds a memory-wait timeout, fault reporting and ecall-halt sequencing.
// Sits between the shared IR/ALUOut/MDR datapath registers and the memory port of the CPU top.
// PARAMETERS
// TIMEOUT  255  max wait cycles for mem_ready in IF/MEM before entering FAULT; must be 1..2**CNT_W-1
// CNT_W    8    width of the memory-wait counter
// PORTS
// clk          in   1  clock; all state updates on the rising edge
// reset_n      in   1  asynchronous active-low reset
// opcode       in   7  instruction[6:0] from IR (valid from ID onward)
// bcond        in   1  ALU branch-condition result (sampled in EX of branch)
// halt_cond    in   1  x17==10 (decoded externally); sampled in ID of ecall
// mem_ready    in   1  memory completes current access this cycle
// mem_read     out  1  memory read request; held until mem_ready
// mem_write    out  1  memory write request; held until mem_ready
// i_or_d       out  1  mem address select: 0=PC, 1=ALUOut
// ir_write     out  1  latch mem dout into IR
// pc_write     out  1  update PC this edge
// pc_src       out  2  0=PC+4, 1=ALUOut (PC+imm from ID), 2=alu_result&~1 (jalr)
// reg_write    out  1  register file write enable
// wb_sel       out  2  0=ALUOut, 1=MDR, 2=PC+4
// alu_src_a    out  2  0=PC, 1=rs1, 2=zero
// alu_src_b    out  2  0=rs2, 1=imm, 2=const 4
// alu_op       out  2  0=add, 1=branch compare, 2=funct-decoded
// is_halted    out  1  sticky; high in HALT or FAULT
// fault        out  1  sticky; high in FAULT only
// state        out  3  current state encoding (debug)
// BEHAVIOUR
// - States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, FAULT=6. Async reset -> IF, wait counter 0.
// - All strobes are decoded combinationally from state/opcode. All are forced 0 while reset_n is low.
// - Unlisted strobes are 0; unlisted selects are 0.
// - IF: mem_read=1, i_or_d=0. On mem_ready: ir_write=1, go to ID. Otherwise stay.
// - ID: alu_src_a=0, alu_src_b=1, alu_op=0 (ALUOut<=PC+imm).
//   - ecall (1110011) with halt_cond=1 -> HALT.
//   - ecall with halt_cond=0 -> pc_write=1, pc_src=0, go to IF.
//   - All other opcodes -> EX.
// - EX, decoded by opcode:
//   - R 0110011: a=1, b=0, op=2 -> WB.
//   - I-ALU 0010011: a=1, b=1, op=2 -> WB.
//   - LUI 0110111: a=2, b=1, op=0 -> WB.
//   - AUIPC 0010111: a=0, b=1, op=0 -> WB.
//   - LOAD 0000011 / STORE 0100011: a=1, b=1, op=0 -> MEM.
//   - BRANCH 1100011: a=1, b=0, op=1, pc_write=1, pc_src = bcond ? 1 : 0 -> IF.
//   - JAL 1101111: reg_write=1, wb_sel=2, pc_write=1, pc_src=1 -> IF.
//   - JALR 1100111: a=1, b=1, op=0, reg_write=1, wb_sel=2, pc_write=1, pc_src=2 -> IF.
//   - Any other opcode -> FAULT.
// - MEM: i_or_d=1. mem_read=1 (load) or mem_write=1 (store).
//   - Load on mem_ready -> WB.
//   - Store on mem_ready: pc_write=1, pc_src=0 -> IF.
// - WB: reg_write=1, wb_sel=1 (load) else 0; pc_write=1, pc_src=0 -> IF.
// - Wait counter:
//   - Increments each IF/MEM cycle with mem_ready=0. Clears on mem_ready and on every state change.
//   - Counter==TIMEOUT with mem_ready=0 -> FAULT.
//   - mem_ready=1 in the same cycle as counter==TIMEOUT: the access completes; no fault.
// - mem_ready is ignored outside IF and MEM. Requests are never withdrawn before mem_ready.
// - HALT, FAULT: terminal until reset. All strobes 0, is_halted=1. fault=1 in FAULT only.
// - Reset during a pending access abandons it. The next request restarts from IF, PC=0 (PC owned externally).
// - Retire points: WB; store completion; branch/JAL/JALR EX; non-halting ecall ID.
// CONFIGURATION
// - INSTRET_CNT_EN defined: adds output instret[31:0].
//   - Reset 0; +1 on every retire point; wraps at 2**32.
//   - Holds in HALT/FAULT. The halting ecall does not count.
// - INSTRET_CNT_EN undefined: no port, no counter logic.
// TESTING
// - ADD, mem_ready=1 every cycle -> IF,ID,EX,WB,IF; reg_write=1 and pc_write=1 only in WB; 4 cycles.
// - LW, mem_ready delayed 3 cycles in both IF and MEM -> mem_read held 4 cycles each time; 11 cycles total.
// - BEQ with bcond=1 -> pc_src=1 in EX. BEQ with bcond=0 -> pc_src=0. Both 3 cycles, no reg_write.
// - mem_ready held 0 in IF with TIMEOUT=4 -> FAULT after 5 IF cycles; fault=1, is_halted=1, strobes 0.
// - TIMEOUT=4, mem_ready=1 on 5th IF cycle -> no fault; ir_write=1; go to ID.
// - ecall with halt_cond=1 -> HALT after ID; is_halted=1.
// - ecall halt_cond=1 then reset_n pulse mid-IF wait -> state=IF, is_halted=0, counter 0.
// - INSTRET_CNT_EN: 5-instruction program ending in a halting ecall -> instret=4.

Source files
------------

// File: rtl/mc_control_fsm.sv
// =============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB) with memory-wait
//               timeout, fault reporting and ecall halt. Optional macro
//               INSTRET_CNT_EN adds a retired-instruction counter output.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module mc_control_fsm #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        halt_cond,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        is_halted,
    output logic        fault,
`ifdef INSTRET_CNT_EN
    output logic [31:0] instret,
`endif
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EX    = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_ECALL  = 7'b1110011;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_halted_q, is_halted_d;
    logic             fault_q, fault_d;

    logic       w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_pc_src, w_wb_sel, w_alu_src_a, w_alu_src_b, w_alu_op;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_i_or_d    = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'd0;
        w_reg_write = 1'b0;
        w_wb_sel    = 2'd0;
        w_alu_src_a = 2'd0;
        w_alu_src_b = 2'd0;
        w_alu_op    = 2'd0;

        unique case (state_q)
            S_IF: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    state_d    = S_ID;
                end
            end
            S_ID: begin
                // ALUOut <= PC + imm, used later as branch/JAL target
                w_alu_src_b = 2'd1;
                if (opcode == c_OP_ECALL) begin
                    if (halt_cond) begin
                        state_d = S_HALT;
                    end else begin
                        w_pc_write = 1'b1;
                        state_d    = S_IF;
                    end
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                unique case (opcode)
                    c_OP_R: begin
                        w_alu_src_a = 2'd1;
                        w_alu_op    = 2'd2;
                        state_d     = S_WB;
                    end
                    c_OP_IALU: begin
                        w_alu_src_a = 2'd1;
                        w_alu_src_b = 2'd1;
                        w_alu_op    = 2'd2;
                        state_d     = S_WB;
                    end
                    c_OP_LUI: begin
                        w_alu_src_a = 2'd2;
                        w_alu_src_b = 2'd1;
                        state_d     = S_WB;
                    end
                    c_OP_AUIPC: begin
                        w_alu_src_b = 2'd1;
                        state_d     = S_WB;
                    end
                    c_OP_LOAD, c_OP_STORE: begin
                        w_alu_src_a = 2'd1;
                        w_alu_src_b = 2'd1;
                        state_d     = S_MEM;
                    end
                    c_OP_BRANCH: begin
                        w_alu_src_a = 2'd1;
                        w_alu_op    = 2'd1;
                        w_pc_write  = 1'b1;
                        w_pc_src    = bcond ? 2'd1 : 2'd0;
                        state_d     = S_IF;
                    end
                    c_OP_JAL: begin
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'd2;
                        w_pc_write  = 1'b1;
                        w_pc_src    = 2'd1;
                        state_d     = S_IF;
                    end
                    c_OP_JALR: begin
                        w_alu_src_a = 2'd1;
                        w_alu_src_b = 2'd1;
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'd2;
                        w_pc_write  = 1'b1;
                        w_pc_src    = 2'd2;
                        state_d     = S_IF;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                w_i_or_d = 1'b1;
                if (opcode == c_OP_STORE) begin
                    w_mem_write = 1'b1;
                    if (mem_ready) begin
                        w_pc_write = 1'b1;
                        state_d    = S_IF;
                    end
                end else begin
                    w_mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_wb_sel    = (opcode == c_OP_LOAD) ? 2'd1 : 2'd0;
                w_pc_write  = 1'b1;
                state_d     = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // A completing access in the timeout cycle still wins over the fault
        if ((state_q == S_IF || state_q == S_MEM) && !mem_ready) begin
            if (cnt_q == c_TIMEOUT) begin
                state_d = S_FAULT;
            end else begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end

        is_halted_d = (state_d == S_HALT) || (state_d == S_FAULT);
        fault_d     = (state_d == S_FAULT);
    end

`ifdef INSTRET_CNT_EN
    logic [31:0] instret_q, instret_d;

    // pc_write is asserted exactly at the retire points
    always_comb begin
        instret_d = w_pc_write ? instret_q + 32'd1 : instret_q;
    end

    assign instret = instret_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IF;
            cnt_q       <= '0;
            is_halted_q <= 1'b0;
            fault_q     <= 1'b0;
`ifdef INSTRET_CNT_EN
            instret_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_halted_q <= is_halted_d;
            fault_q     <= fault_d;
`ifdef INSTRET_CNT_EN
            instret_q   <= instret_d;
`endif
        end
    end

    assign mem_read  = reset_n & w_mem_read;
    assign mem_write = reset_n & w_mem_write;
    assign i_or_d    = reset_n & w_i_or_d;
    assign ir_write  = reset_n & w_ir_write;
    assign pc_write  = reset_n & w_pc_write;
    assign reg_write = reset_n & w_reg_write;
    assign pc_src    = reset_n ? w_pc_src    : 2'd0;
    assign wb_sel    = reset_n ? w_wb_sel    : 2'd0;
    assign alu_src_a = reset_n ? w_alu_src_a : 2'd0;
    assign alu_src_b = reset_n ? w_alu_src_b : 2'd0;
    assign alu_op    = reset_n ? w_alu_op    : 2'd0;
    assign is_halted = is_halted_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

`default_nettype wire
